// File: rtl/skeleton_pass_controller.sv
// Frame store and pass sequencer for the thinning datapath: loads an N*N frame, feeds the
// mask stage, merges its write-back, and repeats passes until the frame stops changing.
//
// state   | meaning
// LOAD    | accepting host pixels into the frame
// IDLE    | frame loaded, waiting for start
// FEED    | mask stage reading the frame (mask_we high)
// COLLECT | merging mask write-back into the frame
// DECIDE  | one cycle: tally the pass and pick another pass or DONE
// DONE    | converged or pass limit reached; frame readable
module skeleton_pass_controller #(
    parameter int N          = 8,
    parameter int BIT_SIZE   = 6,
    parameter int MAX_PASSES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_valid,
    input  logic [7:0]          load_data,
    output logic                load_ready,
    input  logic                start,
    output logic                mask_we,
    output logic [7:0]          mask_data,
    input  logic [BIT_SIZE:0]   mask_address,
    input  logic [7:0]          mask_output,
    input  logic                mask_write_out_enable,
    input  logic [BIT_SIZE:0]   rd_addr,
    output logic [7:0]          rd_data,
    output logic                busy,
    output logic                done,
    output logic [7:0]          pass_count,
    output logic [BIT_SIZE+1:0] change_count
);
    localparam int AW   = BIT_SIZE + 1;
    localparam int NPIX = N * N;
    localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;

    typedef enum logic [2:0] {
        S_LOAD, S_IDLE, S_FEED, S_COLLECT, S_DECIDE, S_DONE
    } state_t;

    state_t          state;
    logic [7:0]      frame [NPIX];
    logic [AW-1:0]   idx;
    logic [AW-1:0]   prev_addr;
    logic [AW:0]     changed;

    logic            capture;
    logic            pix_changed;
    logic            frame_we;
    logic [IW-1:0]   frame_waddr;
    logic [7:0]      frame_wdata;
    logic [7:0]      mask_rd;
    logic [7:0]      host_rd;
    logic [7:0]      prev_rd;

    // Addresses beyond the frame read as zero and never write.
    always_comb begin
        mask_rd = ({1'b0, mask_address} < (AW+1)'(NPIX)) ? frame[mask_address[IW-1:0]] : 8'h00;
        host_rd = ({1'b0, rd_addr} < (AW+1)'(NPIX)) ? frame[rd_addr[IW-1:0]] : 8'h00;
        prev_rd = frame[prev_addr[IW-1:0]];
    end

    assign load_ready = (state == S_LOAD);

    always_comb begin
        capture     = 1'b0;
        pix_changed = 1'b0;
        frame_we    = 1'b0;
        frame_waddr = idx[IW-1:0];
        frame_wdata = load_data;
        if (state == S_LOAD) begin
            frame_we = load_valid;
        end else if (state == S_COLLECT) begin
            capture     = mask_write_out_enable ? (mask_address != prev_addr) : 1'b1;
            pix_changed = capture && (mask_output != prev_rd)
                          && ({1'b0, prev_addr} < (AW+1)'(NPIX));
            frame_we    = pix_changed;
            frame_waddr = prev_addr[IW-1:0];
            frame_wdata = mask_output;
        end
        if (rst) frame_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (frame_we) frame[frame_waddr] <= frame_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_LOAD;
            idx          <= '0;
            prev_addr    <= '0;
            changed      <= '0;
            mask_we      <= 1'b0;
            mask_data    <= 8'h00;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass_count   <= 8'h00;
            change_count <= '0;
            rd_data      <= 8'h00;
        end else begin
            rd_data <= host_rd;
            case (state)
                S_LOAD: begin
                    if (load_valid) begin
                        if (idx == AW'(NPIX - 1)) begin
                            idx   <= '0;
                            state <= S_IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pass_count   <= 8'h00;
                        change_count <= '0;
                        changed      <= '0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        mask_we      <= 1'b1;
                        mask_data    <= mask_rd;
                        state        <= S_FEED;
                    end else if (state == S_DONE && load_valid) begin
                        done  <= 1'b0;
                        idx   <= '0;
                        state <= S_LOAD;
                    end
                end
                S_FEED: begin
                    if (mask_write_out_enable) begin
                        mask_we   <= 1'b0;
                        prev_addr <= mask_address;
                        state     <= S_COLLECT;
                    end else begin
                        mask_data <= mask_rd;
                    end
                end
                S_COLLECT: begin
                    if (capture) begin
                        if (pix_changed) changed <= changed + 1'b1;
                        if (mask_write_out_enable) prev_addr <= mask_address;
                        else state <= S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    pass_count   <= (pass_count == 8'hFF) ? pass_count : pass_count + 8'd1;
                    change_count <= changed;
                    changed      <= '0;
                    if (changed == '0 || ({1'b0, pass_count} + 9'd1 == 9'(MAX_PASSES))) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        mask_we   <= 1'b1;
                        mask_data <= mask_rd;
                        state     <= S_FEED;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_skeleton_pass_controller.sv
// Bench for skeleton_pass_controller: emulates the mask stage, keeps a frame-level reference
// model of every pass, and checks counters, handshakes and the read port.
module tb_skeleton_pass_controller;
    localparam int N = 8, BIT_SIZE = 6, MAX_PASSES = 16, AW = 7, NPIX = 64;
    localparam int IMG_ZERO = 0, IMG_BLOCK = 1, IMG_RAMP = 2, IMG_RAND = 3;
    localparam int M_IDENT = 0, M_CORNER = 1, M_FLIP9 = 2, M_RAND = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_valid;
    logic [7:0]    load_data;
    logic          load_ready;
    logic          start;
    logic          mask_we;
    logic [7:0]    mask_data;
    logic [AW-1:0] mask_address;
    logic [7:0]    mask_output;
    logic          mask_write_out_enable;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          busy;
    logic          done;
    logic [7:0]    pass_count;
    logic [AW:0]   change_count;

    always #5 clk = ~clk;

    skeleton_pass_controller #(.N(N), .BIT_SIZE(BIT_SIZE), .MAX_PASSES(MAX_PASSES)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .start(start), .mask_we(mask_we), .mask_data(mask_data),
        .mask_address(mask_address), .mask_output(mask_output),
        .mask_write_out_enable(mask_write_out_enable), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .pass_count(pass_count), .change_count(change_count)
    );

    typedef struct {
        int img;
        int mode;
        int exp_passes;
        int exp_changes;
    } vec_t;

    int         vec_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] ref_frame [NPIX];
    logic [7:0] result [NPIX];
    int         ref_passes;
    bit         inject_feed_start;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic fill_image(input int kind);
        for (int i = 0; i < NPIX; i++) begin
            case (kind)
                IMG_BLOCK: ref_frame[i] = ((i / N) >= 2 && (i / N) <= 5 && (i % N) >= 2 && (i % N) <= 5)
                                          ? 8'hFF : 8'h00;
                IMG_RAMP:  ref_frame[i] = 8'(i);
                IMG_RAND:  ref_frame[i] = 8'($urandom);
                default:   ref_frame[i] = 8'h00;
            endcase
        end
    endtask

    // What the emulated mask stage writes back for one pass, computed from the reference frame.
    task automatic compute_result(input int mode, input int pass_idx, input int rand_k);
        int cs[4];
        bit hit;
        cs = '{18, 21, 42, 45};
        hit = 1'b0;
        for (int i = 0; i < NPIX; i++) result[i] = ref_frame[i];
        case (mode)
            M_CORNER: for (int j = 0; j < 4; j++)
                          if (!hit && result[cs[j]] != 8'h00) begin
                              result[cs[j]] = 8'h00;
                              hit = 1'b1;
                          end
            M_FLIP9:  result[9] = ~ref_frame[9];
            M_RAND:   if (pass_idx < rand_k)
                          repeat ($urandom_range(1, 4)) result[$urandom_range(0, NPIX - 1)] = 8'($urandom);
            default: ;
        endcase
    endtask

    task automatic load_frame();
        if (done === 1'b1) begin
            load_valid = 1'b1;
            load_data  = 8'hA5;
            cyc();
            chk("done_to_load", load_ready, 1);
        end
        for (int i = 0; i < NPIX; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                load_valid = 1'b0;
                cyc();
            end
            if (i == NPIX - 1) chk("load_ready_last", load_ready, 1);
            load_valid = 1'b1;
            load_data  = ref_frame[i];
            cyc();
        end
        load_valid = 1'b0;
        chk("load_ready_drop", load_ready, 0);
    endtask

    task automatic start_passes();
        start = 1'b1;
        cyc();
        start = 1'b0;
        ref_passes = 0;
        chk("start_busy", busy, 1);
        chk("start_pass_clr", pass_count, 0);
        chk("start_chg_clr", change_count, 0);
        chk("start_mask_we", mask_we, 1);
        chk("start_done", done, 0);
    endtask

    task automatic run_pass(input int mode, input int pass_idx, input int rand_k,
                            input int abort_at, output bit stopped);
        int nchg;
        bit stop;
        stopped = 1'b0;
        compute_result(mode, pass_idx, rand_k);
        mask_write_out_enable = 1'b0;
        for (int k = 0; k < NPIX; k++) begin
            mask_address = AW'(k);
            if (inject_feed_start && pass_idx == 0 && k == 10) start = 1'b1;
            cyc();
            start = 1'b0;
            cyc();
            chk("feed_data", mask_data, ref_frame[k]);
        end
        chk("feed_we", mask_we, 1);
        chk("feed_busy", busy, 1);
        mask_write_out_enable = 1'b1;
        mask_address = '0;
        mask_output  = 8'h00;
        cyc();
        cyc();
        chk("collect_we", mask_we, 0);
        for (int k = 1; k < NPIX; k++) begin
            mask_address = AW'(k);
            mask_output  = result[k-1];
            rd_addr      = AW'(k - 1);
            if (k == abort_at) begin
                rst = 1'b1;
                cyc();
                rst = 1'b0;
                mask_write_out_enable = 1'b0;
                chk("abort_load", load_ready, 1);
                chk("abort_we", mask_we, 0);
                chk("abort_busy", busy, 0);
                chk("abort_pass", pass_count, 0);
                chk("abort_done", done, 0);
                stopped = 1'b1;
                return;
            end
            cyc();
            chk("rd_collide", rd_data, ref_frame[k-1]);
            cyc();
        end
        mask_write_out_enable = 1'b0;
        mask_output = result[NPIX-1];
        cyc();
        cyc();
        nchg = 0;
        for (int i = 0; i < NPIX; i++) if (result[i] != ref_frame[i]) nchg++;
        for (int i = 0; i < NPIX; i++) ref_frame[i] = result[i];
        ref_passes++;
        stop = (nchg == 0) || (ref_passes >= MAX_PASSES);
        chk("pass_count", pass_count, ref_passes);
        chk("change_count", change_count, nchg);
        chk("done", done, stop);
        chk("busy", busy, !stop);
        chk("next_we", mask_we, !stop);
        stopped = stop;
    endtask

    task automatic run_passes(input int mode, input int rand_k);
        bit stopped;
        stopped = 1'b0;
        for (int p = 0; p < MAX_PASSES + 2 && !stopped; p++) run_pass(mode, p, rand_k, -1, stopped);
        if (!stopped) chk("pass_budget", 0, 1);
    endtask

    task automatic readback();
        for (int i = 0; i < NPIX; i++) begin
            rd_addr = AW'(i);
            cyc();
            chk("readback", rd_data, ref_frame[i]);
        end
    endtask

    initial begin
        vec_t vecs[4];
        bit   stopped;
        vecs[0] = '{IMG_ZERO,  M_IDENT,  1,  0};
        vecs[1] = '{IMG_BLOCK, M_CORNER, 5,  0};
        vecs[2] = '{IMG_ZERO,  M_FLIP9,  16, 1};
        vecs[3] = '{IMG_RAMP,  M_IDENT,  1,  0};

        rst = 1'b1; load_valid = 1'b0; load_data = 8'h00; start = 1'b0;
        mask_address = '0; mask_output = 8'h00; mask_write_out_enable = 1'b0; rd_addr = '0;
        inject_feed_start = 1'b0;
        cyc();
        cyc();
        chk("rst_load_ready", load_ready, 1);
        chk("rst_mask_we", mask_we, 0);
        chk("rst_mask_data", mask_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass_count, 0);
        chk("rst_chg", change_count, 0);
        chk("rst_rd_data", rd_data, 0);
        rst = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("start_in_load", load_ready, 1);
        chk("start_in_load_busy", busy, 0);

        for (int v = 0; v < 4; v++) begin
            fill_image(vecs[v].img);
            load_frame();
            if (v == 3) begin
                load_valid = 1'b1;
                load_data  = 8'h77;
                repeat (3) cyc();
                load_valid = 1'b0;
                chk("idle_load_ready", load_ready, 0);
                chk("idle_busy", busy, 0);
                chk("idle_done", done, 0);
                inject_feed_start = 1'b1;
            end
            start_passes();
            run_passes(vecs[v].mode, 0);
            inject_feed_start = 1'b0;
            chk("vec_passes", pass_count, vecs[v].exp_passes);
            chk("vec_changes", change_count, vecs[v].exp_changes);
            chk("vec_done", done, 1);
            if (v == 2) begin
                start_passes();
                run_passes(M_IDENT, 0);
                chk("rerun_passes", pass_count, 1);
            end
            if (v == 3) begin
                rd_addr = AW'(37);
                cyc();
                chk("ramp_rd37", rd_data, 37);
            end
            readback();
        end

        fill_image(IMG_RAND);
        load_frame();
        start_passes();
        run_pass(M_FLIP9, 0, 0, -1, stopped);
        run_pass(M_FLIP9, 1, 0, 30, stopped);

        for (int r = 0; r < 5; r++) begin
            fill_image(IMG_RAND);
            load_frame();
            start_passes();
            run_passes(M_RAND, (r == 4) ? 20 : int'($urandom_range(0, 6)));
            readback();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
